// File: rtl/cbsc_pkg.sv
// cbsc_pkg: shared types and defaults for the CBSC partial-sum accumulator
package cbsc_pkg;
  typedef enum logic [1:0] {IDLE, PRIME, RUN, DONE} state_t;
  localparam int CBSC_DATA_W = 7;
  localparam int CBSC_WIN_LEN = 128;
endpackage

// File: rtl/cbsc_psum_acc_if.sv
// cbsc_psum_acc_if: MAC sample input and valid/ready result bundle
interface cbsc_psum_acc_if import cbsc_pkg::*; #(
  parameter int DATA_W = CBSC_DATA_W,
  parameter int ACC_W = 10
);
  logic start;
  logic [DATA_W-1:0] q_in;
  logic out_ready;
  logic mac_rst;
  logic busy;
  logic [ACC_W-1:0] acc_out;
  logic acc_valid;
  logic acc_sat;
  modport master(output start, q_in, out_ready, input mac_rst, busy, acc_out, acc_valid, acc_sat);
  modport slave(input start, q_in, out_ready, output mac_rst, busy, acc_out, acc_valid, acc_sat);
endinterface

// File: rtl/cbsc_win_timer.sv
// cbsc_win_timer: window cycle counter with registered terminal-count flag
module cbsc_win_timer #(
  parameter int WIN_LEN = 128,
  parameter int CW = $clog2(WIN_LEN)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);
  logic [CW-1:0] win_cnt;
  // count up while enabled, stopping at the terminal value so it never wraps
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      win_cnt <= '0;
      tc <= 1'b0;
    end else if (en && !tc) begin
      win_cnt <= win_cnt + 1'b1;
      tc <= win_cnt == CW'(WIN_LEN - 2);
    end
  end
endmodule

// File: rtl/cbsc_psum_acc.sv
// cbsc_psum_acc: windowed MAC sampling with saturating accumulation and valid/ready result
module cbsc_psum_acc import cbsc_pkg::*; #(
  parameter int DATA_W = CBSC_DATA_W,
  parameter int WIN_LEN = CBSC_WIN_LEN,
  parameter int NUM_WIN = 4,
  parameter int ACC_W = 10
) (
  input logic clk,
  input logic rst,
  cbsc_psum_acc_if.slave bus
);
  localparam int IW = NUM_WIN > 1 ? $clog2(NUM_WIN) : 1;
  state_t state, next;
  logic tc, take, term, last;
  logic [IW-1:0] win_idx;
  logic [DATA_W-1:0] q;
  logic [ACC_W-1:0] acc;
  logic [ACC_W:0] sum;
  logic sat, mac_rst, busy, valid, mac_rst_d, busy_d, valid_d;
  cbsc_win_timer #(.WIN_LEN(WIN_LEN)) u_timer (
    .clk(clk),
    .rst(rst),
    .clr(state != RUN),
    .en(state == RUN),
    .tc(tc)
  );
  assign q = bus.q_in;
  assign take = bus.start && (state == IDLE || (state == DONE && bus.out_ready));
  assign term = state == RUN && tc;
  assign last = win_idx == IW'(NUM_WIN - 1);
  assign sum = {1'b0, acc} + (ACC_W + 1)'(q);
  // next-state decode
  always_comb begin
    next = state;
    case (state)
      IDLE: next = take ? PRIME : IDLE;
      PRIME: next = RUN;
      RUN: next = term ? (last ? DONE : PRIME) : RUN;
      DONE: next = take ? PRIME : bus.out_ready ? IDLE : DONE;
      default: next = IDLE;
    endcase
  end
  // outputs decoded from the next state so they can be registered alongside it
  always_comb begin
    mac_rst_d = next != RUN;
    busy_d = next == PRIME || next == RUN;
    valid_d = next == DONE;
  end
  // state, registered outputs, window index and saturating accumulator
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      mac_rst <= 1'b1;
      busy <= 1'b0;
      valid <= 1'b0;
      win_idx <= '0;
      acc <= '0;
      sat <= 1'b0;
    end else begin
      state <= next;
      mac_rst <= mac_rst_d;
      busy <= busy_d;
      valid <= valid_d;
      if (take) begin
        win_idx <= '0;
        acc <= '0;
        sat <= 1'b0;
      end else if (term) begin
        win_idx <= last ? win_idx : win_idx + 1'b1;
        acc <= sum[ACC_W] ? '1 : sum[ACC_W-1:0];
        sat <= sat | sum[ACC_W];
      end
    end
  end
  assign bus.mac_rst = mac_rst;
  assign bus.busy = busy;
  assign bus.acc_valid = valid;
  assign bus.acc_out = acc;
  assign bus.acc_sat = sat;
endmodule
